// File: rtl/rom_loader_pkg.sv
// Shared types and default sizing for the ROM stream loader.
package rom_loader_pkg;
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PAD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ROM_DEPTH  = 16;
  localparam int DEF_PAD_VALUE  = 0;
endpackage

// File: rtl/rom_sp_mem.sv
// ROM_DEPTH x DATA_WIDTH array: one write port, one registered read port.
module rom_sp_mem
  import rom_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    ROM_DEPTH  = DEF_ROM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(DEF_PAD_VALUE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(ROM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [ROM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is never cleared; only the read register carries reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Addresses beyond the populated depth read back as the pad word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = ({1'b0, rd_addr} < DEPTH_C) ? mem_q[rd_addr] : PAD_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/rom_stream_loader.sv
// Fills an internal ROM from an upstream word stream, pads after EOF,
// then serves registered reads once the image is complete.
module rom_stream_loader
  import rom_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    ROM_DEPTH  = DEF_ROM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(DEF_PAD_VALUE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eof,
  output logic                  in_ready,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  loaded,
  output logic [ADDR_WIDTH:0]   load_count
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(ROM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH + 1)'(ROM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  loaded_q, loaded_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      loaded_q     <= loaded_d;
    end
  end

  // A write into the last slot finishes the image even if EOF arrives with it.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + ONE_C;
          if (load_count_q != DEPTH_C) load_count_d = load_count_q + ONE_C;
        end
        if (in_valid && (wr_ptr_q == LAST_C)) state_d = DONE;
        else if (in_eof) state_d = (wr_ptr_d == DEPTH_C) ? DONE : PAD;
      end
      PAD: begin
        wr_ptr_d = wr_ptr_q + ONE_C;
        if (wr_ptr_q == LAST_C) state_d = DONE;
      end
      default: ;
    endcase
    loaded_d = (state_d == DONE);
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = in_data;
    case (state_q)
      LOAD: begin
        in_ready = !reset;
        mem_we   = !reset && in_valid;
      end
      PAD: begin
        mem_we    = !reset;
        mem_wdata = PAD_VALUE;
      end
      default: ;
    endcase
  end

  rom_sp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_DEPTH  (ROM_DEPTH),
    .PAD_VALUE  (PAD_VALUE)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (mem_wdata),
    .rd_en   (loaded_q && enable),
    .rd_addr (address),
    .rd_data (data_out)
  );

  assign loaded     = loaded_q;
  assign load_count = load_count_q;
endmodule
